// File: rtl/bb_uart_frame_rx_pkg.sv
// Shared types and constants for the bus-bridge UART frame receiver.
package bb_uart_pkg;

  localparam int unsigned FRAME_BYTES = 3;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned WR_BIT      = 7;
  localparam int unsigned MAX_ADDR_W  = 15;

  // Position of the next expected byte within a 3-byte request frame.
  typedef enum logic [1:0] {
    IDX_B0 = 2'd0,
    IDX_B1 = 2'd1,
    IDX_B2 = 2'd2
  } frame_idx_t;

  // Bit-level receive state of the 8N1 deserialiser.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Assembled request frame at full address width.
  typedef struct packed {
    logic                  wr;
    logic [MAX_ADDR_W-1:0] addr;
    logic [BYTE_W-1:0]     data;
  } frame_t;

endpackage

// File: rtl/bb_uart_frame_rx_if.sv
// Valid/ready frame port between the UART receiver and the local bus-master adapter.
interface bb_uart_frame_rx_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 8
);

  logic              frame_valid;
  logic              frame_ready;
  logic              frame_wr;
  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;

  modport master (
    output frame_valid, frame_wr, frame_addr, frame_data,
    input  frame_ready
  );

  modport slave (
    input  frame_valid, frame_wr, frame_addr, frame_data,
    output frame_ready
  );

endinterface

// File: rtl/bb_uart_frame_rx_uart_rx_byte.sv
// 8N1 byte deserialiser: 2-flop synchroniser, mid-bit sampling, stop-bit check.
module uart_rx_byte
  import bb_uart_pkg::*;
#(
  parameter int unsigned CPP = 5208
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_in,
  output logic              byte_done,
  output logic              byte_err,
  output logic [BYTE_W-1:0] byte_data,
  output logic              active
);

  localparam int unsigned CNT_W = $clog2(CPP);
  localparam int unsigned HALF  = CPP / 2;

  logic             sync1;
  logic             sync2;
  logic             rx_prev;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;

  // Synchronise the line, then walk start/data/stop with a per-bit counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      byte_data <= '0;
      byte_done <= 1'b0;
      byte_err  <= 1'b0;
      active    <= 1'b0;
    end else begin
      sync1     <= rx_in;
      sync2     <= sync1;
      rx_prev   <= sync2;
      byte_done <= 1'b0;
      byte_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_prev && !sync2) begin
            state  <= RX_START;
            active <= 1'b1;
          end
        end
        RX_START: begin
          if (cnt == CNT_W'(HALF - 1)) begin
            cnt <= '0;
            if (sync2) begin
              state  <= RX_IDLE;
              active <= 1'b0;
            end else begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt == CNT_W'(CPP - 1)) begin
            cnt       <= '0;
            byte_data <= {sync2, byte_data[BYTE_W-1:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= RX_STOP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          if (cnt == CNT_W'(CPP - 1)) begin
            cnt    <= '0;
            state  <= RX_IDLE;
            active <= 1'b0;
            if (sync2) begin
              byte_done <= 1'b1;
            end else begin
              byte_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/bb_uart_frame_rx.sv
// Bus-bridge UART frame receiver: assembles {wr, addr, data} frames from 8N1 bytes.
// Optional inter-byte timeout enabled by defining BB_RX_TIMEOUT_EN.
module bb_uart_frame_rx
  import bb_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH            = 8,
  parameter int unsigned BB_ADDR_WIDTH         = 15,
  parameter int unsigned UART_CLOCKS_PER_PULSE = 5208,
  parameter int unsigned TIMEOUT_BITS          = 20
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                u_rx,
  bb_uart_frame_rx_if.master  frm,
  output logic                frame_err,
  output logic                overflow,
  output logic                busy
);

  logic              byte_done;
  logic              byte_err;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_active;

  frame_idx_t        idx;
  logic [BYTE_W-1:0] b0;
  logic [BYTE_W-1:0] b1;
  frame_t            out_frame;
  logic              valid;
  logic              hs;
  logic              timeout_hit;

  uart_rx_byte #(
    .CPP(UART_CLOCKS_PER_PULSE)
  ) u_byte (
    .clk       (clk),
    .rstn      (rstn),
    .rx_in     (u_rx),
    .byte_done (byte_done),
    .byte_err  (byte_err),
    .byte_data (byte_data),
    .active    (byte_active)
  );

  assign hs               = valid && frm.frame_ready;
  assign frm.frame_valid  = valid;
  assign frm.frame_wr     = out_frame.wr;
  assign frm.frame_addr   = BB_ADDR_WIDTH'(out_frame.addr);
  assign frm.frame_data   = DATA_WIDTH'(out_frame.data);
  assign busy             = byte_active || (idx != IDX_B0);

`ifdef BB_RX_TIMEOUT_EN
  localparam int unsigned GAP_LIMIT = TIMEOUT_BITS * UART_CLOCKS_PER_PULSE;
  localparam int unsigned GAP_W     = $clog2(GAP_LIMIT);

  logic [GAP_W-1:0] gap_cnt;
  logic             gap_run;

  assign gap_run     = (idx != IDX_B0) && !byte_active;
  assign timeout_hit = gap_run && (gap_cnt == GAP_W'(GAP_LIMIT - 1));

  // Idle-gap counter for partial frames; any byte activity restarts it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gap_cnt <= '0;
    end else if (!gap_run || timeout_hit) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |32'(TIMEOUT_BITS);
  assign timeout_hit    = 1'b0;
`endif

  // Frame assembly, single-entry output register and sticky overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx       <= IDX_B0;
      b0        <= '0;
      b1        <= '0;
      out_frame <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= byte_err || timeout_hit;
      if (hs) begin
        valid <= 1'b0;
      end
      if (byte_err || timeout_hit) begin
        idx <= IDX_B0;
      end else if (byte_done) begin
        case (idx)
          IDX_B0: begin
            b0  <= byte_data;
            idx <= IDX_B1;
          end
          IDX_B1: begin
            b1  <= byte_data;
            idx <= IDX_B2;
          end
          default: begin
            idx <= IDX_B0;
            if (!valid || hs) begin
              out_frame.wr   <= b0[WR_BIT];
              out_frame.addr <= {b0[WR_BIT-1:0], b1};
              out_frame.data <= byte_data;
              valid          <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
